pixel_xfer_ctrl: RTL and testbench
==================================

PIXEL_XFER_CTRL -- requirements
Module: pixel_xfer_ctrl

Interface
REQ-001 SHALL use ports, clock and reset first: HCLK in 1, sole clock, all state updates on its rising edge; HRESET in 1, synchronous active-high reset.
REQ-002 SHALL have: start in 1, one-cycle frame start pulse; length in 16, frame rows; width in 16, frame columns; source_addr in 32; dest_addr in 32.
REQ-003 SHALL have master-port signals: m_req out 1; m_write out 1, 1=write, 0=read; m_addr out 32; m_ack in 1, transfer complete.
REQ-004 SHALL have buffer signals: buf_full in 1, input line buffer full; buf_push out 1, read-data capture strobe; res_valid in 1, result FIFO non-empty; res_pop out 1, result consume strobe.
REQ-005 SHALL have status out 3: 000 IDLE, 001 BUSY, 010 DONE, 011 ERROR.

Function
REQ-006 SHALL compute total = length*width as an unsigned 32-bit product, latched at start.
REQ-007 SHALL keep 32-bit counters rd_cnt and wr_cnt, both cleared on accepted start.
REQ-008 SHALL use one word per pixel: read address = source_addr + 4*rd_cnt; write address = dest_addr + 4*wr_cnt; 32-bit modulo wrap with no error.
REQ-009 SHALL implement states IDLE, ARB, READ, WRITE, DONE, ERR.
REQ-010 SHALL, in IDLE, DONE or ERR on start=1: go to ERR if length==0 or width==0, else go to ARB; either way latch all inputs at that edge.
REQ-011 SHALL ignore start in ARB, READ and WRITE.
REQ-012 SHALL, in ARB, treat read as eligible when rd_cnt<total and buf_full==0.
REQ-013 SHALL, in ARB, treat write as eligible when wr_cnt<rd_cnt and res_valid==1.
REQ-014 SHALL, in ARB with one requester eligible, grant that requester at the next edge (state READ or WRITE).
REQ-015 SHALL, in ARB with both eligible, grant round-robin, opposite of last_grant; last_grant reset value = write, so read wins the first tie.
REQ-016 SHALL, in ARB with neither eligible, remain in ARB.
REQ-017 SHALL, in ARB with wr_cnt==total, go to DONE.
REQ-018 SHALL drive m_req=1 in READ and WRITE only, with m_write=1 in WRITE only.
REQ-019 SHALL hold m_addr stable from state entry until m_ack.
REQ-020 SHALL allow at most one outstanding transfer.
REQ-021 SHALL, in READ while m_ack==0, hold state.
REQ-022 SHALL, in READ on m_ack=1: assert buf_push that same cycle combinationally, increment rd_cnt, set last_grant=read, return to ARB.
REQ-023 SHALL, in WRITE on m_ack=1: assert res_pop that same cycle, increment wr_cnt, set last_grant=write, return to ARB.
REQ-024 SHALL keep buf_push and res_pop low at all other times.
REQ-025 SHALL give latency as follows: start at edge N gives ARB after N; first m_req high after edge N+1; minimum 2 cycles per transfer (grant cycle + ack cycle).
REQ-026 SHALL drive status: IDLE=000; ARB/READ/WRITE=001; DONE=010 held until next start; ERR=011 held until next start.
REQ-027 SHALL keep m_addr=0 when m_req==0.

Reset
REQ-028 SHALL, on HRESET=1 at a rising edge, regardless of state including mid-transfer: go to IDLE; clear rd_cnt, wr_cnt and total; set last_grant=write; drive m_req=0, m_write=0, m_addr=0, buf_push=0, res_pop=0, status=000 after that edge.
REQ-029 SHALL give HRESET priority over start and m_ack in the same cycle.

Verification
REQ-030 SHALL cover: length=2, width=2, source 0x00100000, dest 0x00200000, m_ack=1 whenever m_req, res_valid=1, buf_full=0 -> 4 reads and 4 writes alternating R,W,R,W,... with read addresses 0x00100000/04/08/0C and write addresses 0x00200000/04/08/0C; status 001 then 010; 8 buf_push+res_pop strobes total.
REQ-031 SHALL cover: start with width=0 -> status 011 one edge later; m_req never asserted; later valid start -> 001.
REQ-032 SHALL cover: buf_full=1 after first read, res_valid=0 -> state stays ARB, m_req=0, status 001; release buf_full -> next read address source+4.
REQ-033 SHALL cover: m_ack held low 5 cycles in READ -> m_req and m_addr constant for all 5 cycles; buf_push only on the ack cycle.
REQ-034 SHALL cover: HRESET during WRITE with m_req=1 -> after the edge status=000, m_req=0, counters 0; a new start restarts at source_addr.
REQ-035 SHALL cover: start pulsed while BUSY -> ignored, counters and addresses unaffected.

Source files
------------

// File: rtl/pixel_xfer_ctrl.sv
// Frame pixel mover: reads source words into a line buffer and writes
// results back to the destination, arbitrating one bus transfer at a time.
module pixel_xfer_ctrl (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [15:0] length,
    input  logic [15:0] width,
    input  logic [31:0] source_addr,
    input  logic [31:0] dest_addr,
    output logic        m_req,
    output logic        m_write,
    output logic [31:0] m_addr,
    input  logic        m_ack,
    input  logic        buf_full,
    output logic        buf_push,
    input  logic        res_valid,
    output logic        res_pop,
    output logic [2:0]  status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] total_q, total_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic        last_wr_q, last_wr_d;
    logic        rd_ok, wr_ok;

    assign rd_ok = (rd_cnt_q < total_q) && !buf_full;
    assign wr_ok = (wr_cnt_q < rd_cnt_q) && res_valid;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        src_d     = src_q;
        dst_d     = dst_q;
        last_wr_d = last_wr_q;
        m_req     = 1'b0;
        m_write   = 1'b0;
        m_addr    = 32'd0;
        buf_push  = 1'b0;
        res_pop   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    total_d  = 32'(length) * 32'(width);
                    src_d    = source_addr;
                    dst_d    = dest_addr;
                    rd_cnt_d = 32'd0;
                    wr_cnt_d = 32'd0;
                    state_d  = (length == 16'd0 || width == 16'd0) ? S_ERR : S_ARB;
                end
            end
            S_ARB: begin
                // Round-robin: a tie goes to whichever side did not go last.
                if (wr_cnt_q == total_q) begin
                    state_d = S_DONE;
                end else if (rd_ok && (!wr_ok || last_wr_q)) begin
                    state_d = S_READ;
                end else if (wr_ok) begin
                    state_d = S_WRITE;
                end
            end
            S_READ: begin
                m_req  = 1'b1;
                m_addr = src_q + {rd_cnt_q[29:0], 2'b00};
                if (m_ack) begin
                    buf_push  = 1'b1;
                    rd_cnt_d  = rd_cnt_q + 32'd1;
                    last_wr_d = 1'b0;
                    state_d   = S_ARB;
                end
            end
            S_WRITE: begin
                m_req   = 1'b1;
                m_write = 1'b1;
                m_addr  = dst_q + {wr_cnt_q[29:0], 2'b00};
                if (m_ack) begin
                    res_pop   = 1'b1;
                    wr_cnt_d  = wr_cnt_q + 32'd1;
                    last_wr_d = 1'b1;
                    state_d   = S_ARB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (state_q)
            S_IDLE:  status = 3'b000;
            S_DONE:  status = 3'b010;
            S_ERR:   status = 3'b011;
            default: status = 3'b001;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            total_q   <= 32'd0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: tb/tb_pixel_xfer_ctrl.sv
// Bench for pixel_xfer_ctrl: frame table plus hand-built corner sequences,
// bus transfers checked against a queue of expected transactions.
module tb_pixel_xfer_ctrl;

    logic        clk = 1'b0;
    logic        HRESET;
    logic        start;
    logic [15:0] length;
    logic [15:0] width;
    logic [31:0] source_addr;
    logic [31:0] dest_addr;
    logic        m_req;
    logic        m_write;
    logic [31:0] m_addr;
    logic        m_ack;
    logic        buf_full;
    logic        buf_push;
    logic        res_valid;
    logic        res_pop;
    logic [2:0]  status;

    pixel_xfer_ctrl dut (
        .HCLK       (clk),
        .HRESET     (HRESET),
        .start      (start),
        .length     (length),
        .width      (width),
        .source_addr(source_addr),
        .dest_addr  (dest_addr),
        .m_req      (m_req),
        .m_write    (m_write),
        .m_addr     (m_addr),
        .m_ack      (m_ack),
        .buf_full   (buf_full),
        .buf_push   (buf_push),
        .res_valid  (res_valid),
        .res_pop    (res_pop),
        .status     (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
    } xfer_t;

    typedef struct {
        logic [15:0] len;
        logic [15:0] wid;
        logic [31:0] src;
        logic [31:0] dst;
        logic [2:0]  st_start;
        logic [2:0]  st_end;
        int          strobes;
    } vec_t;

    xfer_t sbq[$];
    vec_t  vt[5];
    int    n_chk = 0;
    int    n_fail = 0;
    int    n_strobe = 0;

    localparam logic [31:0] SRC = 32'h0010_0000;
    localparam logic [31:0] DST = 32'h0020_0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pulse_start(input logic [15:0] l, input logic [15:0] w,
                               input logic [31:0] s, input logic [31:0] d);
        @(negedge clk);
        length = l;
        width = w;
        source_addr = s;
        dest_addr = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] w,
                              input logic [31:0] s, input logic [31:0] d);
        logic [31:0] tot;
        tot = 32'(l) * 32'(w);
        for (int i = 0; i < int'(tot); i++) begin
            sbq.push_back('{1'b0, s + 32'(4 * i)});
            sbq.push_back('{1'b1, d + 32'(4 * i)});
        end
    endtask

    task automatic wait_req(input int max);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            m_ack = 1'b0;
            c++;
        end while (!m_req && c < max);
        chk("req_seen", {31'd0, m_req}, 32'd1);
    endtask

    // Acks every request immediately and checks it against the queue head.
    task automatic serve(input int max);
        xfer_t e;
        int c;
        c = 0;
        while (sbq.size() > 0 && c < max) begin
            @(negedge clk);
            m_ack = 1'b0;
            start = 1'b0;
            c++;
            if (m_req) begin
                e = sbq.pop_front();
                chk("xfer_write", {31'd0, m_write}, {31'd0, e.wr});
                chk("xfer_addr", m_addr, e.addr);
                m_ack = 1'b1;
                #1;
                chk("xfer_strobe", {30'd0, buf_push, res_pop}, e.wr ? 32'd1 : 32'd2);
                n_strobe += int'(buf_push) + int'(res_pop);
            end else begin
                chk("idle_addr", m_addr, 32'd0);
            end
        end
        chk("serve_left", sbq.size(), 32'd0);
        sbq.delete();
        @(negedge clk);
        m_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1;
        start = 1'b0;
        length = 16'd0;
        width = 16'd0;
        source_addr = 32'd0;
        dest_addr = 32'd0;
        m_ack = 1'b0;
        buf_full = 1'b0;
        res_valid = 1'b1;

        vt[0] = '{16'd2, 16'd2, SRC, DST, 3'b001, 3'b010, 8};
        vt[1] = '{16'd1, 16'd3, 32'hFFFF_FFF8, 32'h0000_0010, 3'b001, 3'b010, 6};
        vt[2] = '{16'd0, 16'd5, SRC, DST, 3'b011, 3'b011, 0};
        vt[3] = '{16'd3, 16'd1, 32'h0000_1000, 32'h8000_0000, 3'b001, 3'b010, 6};
        vt[4] = '{16'd2, 16'd0, SRC, DST, 3'b011, 3'b011, 0};

        repeat (3) @(negedge clk);
        HRESET = 1'b0;
        @(negedge clk);
        chk("rst_status", {29'd0, status}, 32'd0);
        chk("rst_req", {31'd0, m_req}, 32'd0);
        chk("rst_write", {31'd0, m_write}, 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_strobes", {30'd0, buf_push, res_pop}, 32'd0);

        foreach (vt[i]) begin
            pulse_start(vt[i].len, vt[i].wid, vt[i].src, vt[i].dst);
            chk("st_start", {29'd0, status}, {29'd0, vt[i].st_start});
            chk("req_after_start", {31'd0, m_req}, 32'd0);
            push_frame(vt[i].len, vt[i].wid, vt[i].src, vt[i].dst);
            n_strobe = 0;
            serve(200);
            @(negedge clk);
            chk("st_end", {29'd0, status}, {29'd0, vt[i].st_end});
            chk("strobe_total", n_strobe, vt[i].strobes);
            repeat (3) @(negedge clk);
            chk("req_quiet", {31'd0, m_req}, 32'd0);
            chk("st_hold", {29'd0, status}, {29'd0, vt[i].st_end});
        end

        // Line buffer full with no results: controller must park in ARB.
        res_valid = 1'b0;
        pulse_start(16'd1, 16'd2, SRC, DST);
        wait_req(10);
        chk("bf_rd0_addr", m_addr, SRC);
        m_ack = 1'b1;
        #1;
        chk("bf_rd0_push", {31'd0, buf_push}, 32'd1);
        @(negedge clk);
        m_ack = 1'b0;
        buf_full = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bf_stall_req", {31'd0, m_req}, 32'd0);
            chk("bf_stall_status", {29'd0, status}, 32'd1);
        end
        buf_full = 1'b0;
        wait_req(10);
        chk("bf_rd1_write", {31'd0, m_write}, 32'd0);
        chk("bf_rd1_addr", m_addr, SRC + 32'd4);
        m_ack = 1'b1;
        #1;
        res_valid = 1'b1;
        sbq.push_back('{1'b1, DST});
        sbq.push_back('{1'b1, DST + 32'd4});
        serve(50);
        @(negedge clk);
        chk("bf_done", {29'd0, status}, 32'd2);

        // Slow slave: request and address must hold through the wait.
        pulse_start(16'd1, 16'd1, 32'h0000_4000, 32'h0000_8000);
        wait_req(10);
        for (int k = 0; k < 5; k++) begin
            chk("wait_req", {31'd0, m_req}, 32'd1);
            chk("wait_addr", m_addr, 32'h0000_4000);
            chk("wait_push", {31'd0, buf_push}, 32'd0);
            @(negedge clk);
        end
        m_ack = 1'b1;
        #1;
        chk("wait_ack_push", {31'd0, buf_push}, 32'd1);
        chk("wait_ack_addr", m_addr, 32'h0000_4000);
        sbq.push_back('{1'b1, 32'h0000_8000});
        serve(20);
        @(negedge clk);
        chk("wait_done", {29'd0, status}, 32'd2);

        // A second start while busy must be ignored.
        pulse_start(16'd2, 16'd1, 32'h0003_0000, 32'h0004_0000);
        chk("busy_status", {29'd0, status}, 32'd1);
        length = 16'd9;
        width = 16'd9;
        source_addr = 32'hDEAD_0000;
        dest_addr = 32'hBEEF_0000;
        start = 1'b1;
        push_frame(16'd2, 16'd1, 32'h0003_0000, 32'h0004_0000);
        n_strobe = 0;
        serve(100);
        @(negedge clk);
        chk("busy_done", {29'd0, status}, 32'd2);
        chk("busy_strobes", n_strobe, 32'd4);

        // Reset in the middle of a write, with start and ack also high.
        pulse_start(16'd2, 16'd2, SRC, DST);
        wait_req(10);
        chk("mr_rd_addr", m_addr, SRC);
        m_ack = 1'b1;
        wait_req(10);
        chk("mr_in_write", {31'd0, m_write}, 32'd1);
        chk("mr_wr_addr", m_addr, DST);
        HRESET = 1'b1;
        m_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        HRESET = 1'b0;
        m_ack = 1'b0;
        start = 1'b0;
        chk("mr_status", {29'd0, status}, 32'd0);
        chk("mr_req", {31'd0, m_req}, 32'd0);
        chk("mr_addr", m_addr, 32'd0);
        chk("mr_write", {31'd0, m_write}, 32'd0);
        chk("mr_strobes", {30'd0, buf_push, res_pop}, 32'd0);
        pulse_start(16'd1, 16'd1, SRC, DST);
        chk("mr_restart", {29'd0, status}, 32'd1);
        push_frame(16'd1, 16'd1, SRC, DST);
        serve(20);
        @(negedge clk);
        chk("mr_done", {29'd0, status}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
